// File: rtl/cvp14_pkg.sv
// rtl/cvp14_pkg.sv - shared opcodes, vector geometry and vector-memory FSM state
package cvp14_pkg;

   localparam int LANES  = 16;
   localparam int LANE_W = 16;
   localparam int VEC_W  = LANES * LANE_W;

   localparam logic [3:0] NOP  = 4'b0000;
   localparam logic [3:0] VADD = 4'b0001;
   localparam logic [3:0] VSUB = 4'b0010;
   localparam logic [3:0] VMUL = 4'b0011;
   localparam logic [3:0] VLD  = 4'b0100;
   localparam logic [3:0] VST  = 4'b0101;

   // Highest base address whose 16-lane burst stays inside the 64K word space.
   localparam logic [15:0] WRAP_LIMIT = 16'hFFF0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DRAIN,
      S_DONE
   } vmem_state_t;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == VLD) || (op == VST);
   endfunction

endpackage

// File: rtl/vector_mem_unit.sv
// rtl/vector_mem_unit.sv - 16-lane vector load/store sequencer over a 16-bit word memory
// Optional macro VMEM_WRAP_FAULT_EN: reject bursts that would wrap past 16'hFFFF.
module vector_mem_unit
   import cvp14_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [15:0]      addr,
   input  logic [VEC_W-1:0] wdata,
   output logic [15:0]      mem_addr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   output logic [VEC_W-1:0] rdata,
   output logic             busy,
   output logic             done,
   output logic             fault
);

   vmem_state_t      state;
   logic [3:0]       cnt;
   logic [3:0]       cnt_nxt;
   logic [3:0]       lane_prev;
   logic             is_load;
   logic [15:0]      base;
   logic [VEC_W-1:0] wvec;
   logic             accept;
   logic             overflow;

   assign cnt_nxt   = cnt + 4'd1;
   assign lane_prev = cnt - 4'd1;
   assign accept    = start && is_mem_op(opcode);

`ifdef VMEM_WRAP_FAULT_EN
   logic fault_q;

   assign overflow = (addr > WRAP_LIMIT);
   assign fault    = fault_q;

   always_ff @(posedge clk) begin
      if (rst)
         fault_q <= 1'b0;
      else if (state == S_IDLE && accept)
         fault_q <= overflow;
   end
`else
   assign overflow = 1'b0;
   assign fault    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         is_load   <= 1'b0;
         base      <= 16'd0;
         wvec      <= '0;
         rdata     <= '0;
         mem_addr  <= 16'd0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wdata <= 16'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (accept) begin
                  is_load <= (opcode == VLD);
                  base    <= addr;
                  wvec    <= wdata;
                  cnt     <= 4'd0;
                  busy    <= 1'b1;
                  // A rejected burst still passes through DRAIN so done lands one cycle later.
                  if (overflow) begin
                     state <= S_DRAIN;
                  end else begin
                     state     <= S_XFER;
                     mem_addr  <= addr;
                     mem_rd    <= (opcode == VLD);
                     mem_wr    <= (opcode == VST);
                     mem_wdata <= (opcode == VST) ? wdata[LANE_W-1:0] : 16'd0;
                  end
               end
            end

            S_XFER: begin
               // Read data for the lane issued last cycle arrives now.
               if (is_load && cnt != 4'd0)
                  rdata[{lane_prev, 4'b0000} +: LANE_W] <= mem_rdata;
               cnt <= cnt_nxt;
               if (cnt == 4'd15) begin
                  mem_addr  <= 16'd0;
                  mem_rd    <= 1'b0;
                  mem_wr    <= 1'b0;
                  mem_wdata <= 16'd0;
                  if (is_load) begin
                     state <= S_DRAIN;
                  end else begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  mem_addr  <= base + {12'd0, cnt_nxt};
                  mem_wdata <= is_load ? 16'd0 : wvec[{cnt_nxt, 4'b0000} +: LANE_W];
               end
            end

            S_DRAIN: begin
               if (is_load && !fault)
                  rdata[{4'd15, 4'b0000} +: LANE_W] <= mem_rdata;
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end

            S_DONE: begin
               done  <= 1'b0;
               cnt   <= 4'd0;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_mem_unit.sv
// tb/tb_vector_mem_unit.sv - table-driven scoreboard bench for vector_mem_unit
module tb_vector_mem_unit;
   import cvp14_pkg::*;

`ifdef VMEM_WRAP_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       opcode;
   logic [15:0]      addr;
   logic [VEC_W-1:0] wdata;
   logic [15:0]      mem_addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [15:0]      mem_wdata;
   logic [15:0]      mem_rdata = 16'd0;
   logic [VEC_W-1:0] rdata;
   logic             busy;
   logic             done;
   logic             fault;

   vector_mem_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .opcode   (opcode),
      .addr     (addr),
      .wdata    (wdata),
      .mem_addr (mem_addr),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] addr;
      logic [15:0] seed;
      int          intr;
      int          lat;
      int          nbusy;
      int          nrd;
      logic        flt;
   } vec_t;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [15:0]      mem     [0:65535];
   logic [15:0]      ref_mem [0:65535];
   logic [31:0]      wq[$];
   logic [VEC_W-1:0] exp_rdata;
   bit               mon_en = 1'b0;
   vec_t             tbl[11];

   task automatic chk(input string nm, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   always @(posedge clk) begin
      if (mem_wr === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= (mem_rd === 1'b1) ? mem[mem_addr] : 16'h0000;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_wr) begin
            if (wq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
               logic [31:0] e;
               e = wq.pop_front();
               chk("wr_addr", {240'd0, mem_addr}, {240'd0, e[31:16]});
               chk("wr_data", {240'd0, mem_wdata}, {240'd0, e[15:0]});
            end
         end
         if (mem_rd && mem_wr) chk_int("rd_wr_exclusive", 1, 0);
         if (!busy) begin
            chk("idle_mem_quiet", {220'd0, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
         end
      end
   end

   task automatic run_vec(input vec_t v, input string nm);
      logic [VEC_W-1:0] wv;
      int ndone, dcyc, nbusy, nrd;
      bit mem_op;
      mem_op = (v.op == VLD) || (v.op == VST);
      for (int i = 0; i < LANES; i++) wv[i*LANE_W +: LANE_W] = v.seed + 16'(i);
      if (mem_op && !v.flt) begin
         for (int i = 0; i < LANES; i++) begin
            logic [15:0] a;
            a = v.addr + 16'(i);
            if (v.op == VST) begin
               ref_mem[a] = v.seed + 16'(i);
               wq.push_back({a, v.seed + 16'(i)});
            end else begin
               exp_rdata[i*LANE_W +: LANE_W] = ref_mem[a];
            end
         end
      end
      @(posedge clk); #1;
      start = 1'b1; opcode = v.op; addr = v.addr; wdata = wv;
      @(posedge clk); #1;
      ndone = 0; dcyc = 0; nbusy = 0; nrd = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         if (c == v.intr) begin
            start = 1'b1; opcode = VLD; addr = 16'h0200; wdata = '1;
         end else begin
            start = 1'b0; opcode = NOP;
         end
         @(negedge clk);
         if (done) begin
            ndone++;
            if (dcyc == 0) dcyc = c;
         end
         if (busy) nbusy++;
         if (mem_rd) nrd++;
      end
      chk_int({nm, "_done_cycle"}, dcyc, v.lat);
      chk_int({nm, "_done_count"}, ndone, (v.lat != 0) ? 1 : 0);
      chk_int({nm, "_busy_cycles"}, nbusy, v.nbusy);
      chk_int({nm, "_rd_strobes"}, nrd, v.nrd);
      chk({nm, "_rdata"}, rdata, exp_rdata);
      chk({nm, "_fault"}, {255'd0, fault}, {255'd0, v.flt});
      chk_int({nm, "_writes_left"}, wq.size(), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; opcode = NOP; addr = 16'd0; wdata = '0;
      exp_rdata = '0;
      for (int i = 0; i < 65536; i++) begin
         logic [15:0] v;
         v = 16'd0;
         if (i >= 16'h0200 && i < 16'h0210) v = 16'hA000 + 16'(i - 16'h0200);
         if (i < 8) v = 16'hB000 + 16'(i);
         if (i >= 16'hFFF8) v = 16'hC000 + 16'(i - 16'hFFF8);
         mem[i] = v;
         ref_mem[i] = v;
      end

      tbl[0]  = '{VST, 16'h0100, 16'h0000, 0, 17, 16, 0, 1'b0};
      tbl[1]  = '{VLD, 16'h0200, 16'h0000, 0, 18, 17, 16, 1'b0};
      tbl[2]  = '{VST, 16'h0300, 16'h5550, 0, 17, 16, 0, 1'b0};
      tbl[3]  = '{VLD, 16'h0300, 16'h0000, 0, 18, 17, 16, 1'b0};
      tbl[4]  = '{NOP, 16'h0100, 16'h1234, 0, 0, 0, 0, 1'b0};
      tbl[5]  = '{4'b0110, 16'h0200, 16'h4321, 0, 0, 0, 0, 1'b0};
`ifdef VMEM_WRAP_FAULT_EN
      tbl[6]  = '{VST, 16'hFFF8, 16'h7000, 0, 2, 1, 0, 1'b1};
      tbl[7]  = '{VLD, 16'hFFF8, 16'h0000, 0, 2, 1, 0, 1'b1};
`else
      tbl[6]  = '{VST, 16'hFFF8, 16'h7000, 0, 17, 16, 0, 1'b0};
      tbl[7]  = '{VLD, 16'hFFF8, 16'h0000, 0, 18, 17, 16, 1'b0};
`endif
      tbl[8]  = '{VLD, 16'h0200, 16'h0000, 0, 18, 17, 16, 1'b0};
      tbl[9]  = '{VST, 16'h0400, 16'h1110, 5, 17, 16, 0, 1'b0};
      tbl[10] = '{VST, 16'h0410, 16'h2220, 17, 17, 16, 0, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", {255'd0, busy}, '0);
      chk("reset_done", {255'd0, done}, '0);
      chk("reset_fault", {255'd0, fault}, '0);
      chk("reset_rdata", rdata, '0);
      chk("reset_mem", {222'd0, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
      mon_en = 1'b1;

      for (int k = 0; k < 11; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

      // Reset while lane 7 of a load is being issued.
      @(posedge clk); #1;
      start = 1'b1; opcode = VLD; addr = 16'h0200; wdata = '0;
      @(posedge clk); #1;
      start = 1'b0; opcode = NOP;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      exp_rdata = '0;
      chk("abort_busy", {255'd0, busy}, '0);
      chk("abort_done", {255'd0, done}, '0);
      chk("abort_mem_rd", {255'd0, mem_rd}, '0);
      chk("abort_rdata", rdata, exp_rdata);
      begin
         int nd;
         nd = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) nd++;
         end
         chk_int("abort_no_done", nd, 0);
      end

      run_vec(tbl[1], "after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
